// File: rtl/bundle_fetch_queue.sv
// VLIW fetch front end: credit-limited bundle requests, PC-tagged in-order responses, issue FIFO, redirect flush.
// Optional BUNDLE_FETCH_QUEUE_BYPASS_EN forwards a response straight to issue when the FIFO is empty.
module bundle_fetch_queue #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,            // active-low, asynchronous
   output logic                         o_req_valid,
   input  logic                         i_req_ready,
   output logic [31:0]                  o_req_pc,
   input  logic                         i_rsp_valid,
   input  logic [32*NUM_SLOTS-1:0]      i_rsp_bundle,
   output logic                         o_issue_valid,
   input  logic                         i_issue_ready,
   output logic [32*NUM_SLOTS-1:0]      o_issue_bundle,
   output logic [31:0]                  o_issue_pc,
   input  logic                         i_redirect_valid,
   input  logic [31:0]                  i_redirect_pc,
   output logic                         o_squash,
   output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);
   localparam int unsigned BW    = 32*NUM_SLOTS;
   localparam int unsigned CW    = $clog2(DEPTH+1);
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned ALIGN = $clog2(4*NUM_SLOTS);
   localparam logic [31:0] STRIDE     = 32'(4*NUM_SLOTS);
   localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN) - 32'd1);
   localparam logic [CW:0] DEPTH_C    = (CW+1)'(DEPTH);

   logic [31:0]    r_req_pc;
   logic [CW-1:0]  r_outstanding;
   logic [CW-1:0]  r_drop_cnt;
   logic [CW-1:0]  r_occupancy;
   logic           r_squash;
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [PW-1:0]  r_tag_wr;
   logic [PW-1:0]  r_tag_rd;
   logic [BW-1:0]  r_bundle_mem [DEPTH];
   logic [31:0]    r_pc_mem     [DEPTH];
   logic [31:0]    r_tag_mem    [DEPTH];

   logic           w_req_fire;
   logic           w_rsp_keep;
   logic           w_fifo_empty;
   logic           w_bypass;
   logic           w_push;
   logic           w_pop;
   logic [31:0]    w_rsp_pc;
   logic [CW-1:0]  w_outstanding_next;

   // Credit covers both buffered and in-flight bundles so every response has a slot.
   assign o_req_valid  = (({1'b0, r_occupancy} + {1'b0, r_outstanding}) < DEPTH_C) && !i_redirect_valid;
   assign w_req_fire   = o_req_valid && i_req_ready;
   assign w_fifo_empty = (r_occupancy == '0);
   assign w_rsp_pc     = r_tag_mem[r_tag_rd];
   assign w_rsp_keep   = i_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
   assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(i_rsp_valid);

`ifdef BUNDLE_FETCH_QUEUE_BYPASS_EN
   assign w_bypass = w_fifo_empty && w_rsp_keep;
`else
   assign w_bypass = 1'b0;
`endif

   assign o_issue_valid = (!w_fifo_empty || w_bypass) && !i_redirect_valid;
   assign w_pop         = o_issue_valid && i_issue_ready && !w_fifo_empty;
   assign w_push        = w_rsp_keep && !(w_bypass && i_issue_ready);

   always_comb begin
      o_issue_bundle = '0;
      o_issue_pc     = '0;
      if (!w_fifo_empty) begin
         o_issue_bundle = r_bundle_mem[r_rd_ptr];
         o_issue_pc     = r_pc_mem[r_rd_ptr];
      end
`ifdef BUNDLE_FETCH_QUEUE_BYPASS_EN
      else if (w_bypass) begin
         o_issue_bundle = i_rsp_bundle;
         o_issue_pc     = w_rsp_pc;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_req_pc      <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_occupancy   <= '0;
         r_squash      <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_tag_wr      <= '0;
         r_tag_rd      <= '0;
      end else begin
         r_outstanding <= w_outstanding_next;
         r_squash      <= i_redirect_valid;
         // The tag FIFO keeps running through a flush so stale responses still retire their tags.
         if (w_req_fire)  r_tag_wr <= r_tag_wr + 1'b1;
         if (i_rsp_valid) r_tag_rd <= r_tag_rd + 1'b1;
         if (i_redirect_valid) begin
            r_req_pc    <= i_redirect_pc & ALIGN_MASK;
            r_drop_cnt  <= w_outstanding_next;
            r_occupancy <= '0;
            r_rd_ptr    <= r_wr_ptr;
         end else begin
            if (w_req_fire) r_req_pc <= r_req_pc + STRIDE;
            if (i_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
            r_occupancy <= r_occupancy + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_bundle_mem[r_wr_ptr] <= i_rsp_bundle;
         r_pc_mem[r_wr_ptr]     <= w_rsp_pc;
      end
      if (w_req_fire) r_tag_mem[r_tag_wr] <= r_req_pc;
   end

   assign o_req_pc    = r_req_pc;
   assign o_squash    = r_squash;
   assign o_occupancy = r_occupancy;
endmodule

// File: tb/tb_bundle_fetch_queue.sv
// Directed bench for bundle_fetch_queue (NUM_SLOTS=4, DEPTH=4) with a small in-order memory model.
module tb_bundle_fetch_queue;
`ifdef BUNDLE_FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic         clk;
   logic         i_rst;
   logic         o_req_valid;
   logic         i_req_ready;
   logic [31:0]  o_req_pc;
   logic         i_rsp_valid;
   logic [127:0] i_rsp_bundle;
   logic         o_issue_valid;
   logic         i_issue_ready;
   logic [127:0] o_issue_bundle;
   logic [31:0]  o_issue_pc;
   logic         i_redirect_valid;
   logic [31:0]  i_redirect_pc;
   logic         o_squash;
   logic [2:0]   o_occupancy;

   int n_vec = 0;
   int n_err = 0;

   bundle_fetch_queue #(.NUM_SLOTS(4), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_pc(o_req_pc),
      .i_rsp_valid(i_rsp_valid), .i_rsp_bundle(i_rsp_bundle),
      .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
      .o_issue_bundle(o_issue_bundle), .o_issue_pc(o_issue_pc),
      .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
      .o_squash(o_squash), .o_occupancy(o_occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] bf(input logic [31:0] pc);
      return {~pc, pc ^ 32'h5A5A_5A5A, pc + 32'h8, pc};
   endfunction

   // Memory: one-cycle latency, in order; mem_go=0 holds responses back.
   logic        mem_go;
   logic        fire_pend;
   logic [31:0] fire_pc;
   logic [31:0] mem_q[$];

   always @(negedge clk) begin
      fire_pend = i_rst && o_req_valid && i_req_ready;
      fire_pc   = o_req_pc;
   end

   always @(posedge clk) begin
      #1;
      if (!i_rst) begin
         mem_q.delete();
         i_rsp_valid  = 1'b0;
         i_rsp_bundle = '0;
      end else begin
         if (fire_pend) mem_q.push_back(fire_pc);
         if (mem_go && mem_q.size() > 0) begin
            i_rsp_valid  = 1'b1;
            i_rsp_bundle = bf(mem_q.pop_front());
         end else begin
            i_rsp_valid  = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      i_rst = 1'b0;
      i_req_ready = 1'b0;
      i_issue_ready = 1'b0;
      i_redirect_valid = 1'b0;
      i_redirect_pc = '0;
      mem_go = 1'b1;
      cyc();
      cyc();
   endtask

   initial begin
      i_rsp_valid = 1'b0;
      i_rsp_bundle = '0;
      fire_pend = 1'b0;
      fire_pc = '0;
      do_reset();
      #1;
      chk("rst_req_valid", o_req_valid, 1);
      chk("rst_req_pc", o_req_pc, 32'h0);
      chk("rst_issue_valid", o_issue_valid, 0);
      chk("rst_issue_bundle", o_issue_bundle, 0);
      chk("rst_issue_pc", o_issue_pc, 0);
      chk("rst_squash", o_squash, 0);
      chk("rst_occupancy", o_occupancy, 0);

      // Streaming with a 1-cycle memory and decode always ready.
      i_rst = 1'b1; i_req_ready = 1'b1; i_issue_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         if (n > 0) cyc();
         #1;
         chk("A_req_valid", o_req_valid, 1);
         chk("A_req_pc", o_req_pc, 32'(16*n));
         if (n >= 2 - BYP) begin
            chk("A_issue_valid", o_issue_valid, 1);
            chk("A_issue_pc", o_issue_pc, 32'(16*(n-2+BYP)));
            chk("A_issue_bundle", o_issue_bundle, bf(32'(16*(n-2+BYP))));
         end else begin
            chk("A_issue_valid_lat", o_issue_valid, 0);
         end
         chk("A_occupancy", o_occupancy, (n >= 2 && BYP == 0) ? 1 : 0);
      end

      // Decode stalled: credit stops requests at DEPTH.
      do_reset();
      i_rst = 1'b1; i_req_ready = 1'b1; i_issue_ready = 1'b0;
      for (int n = 0; n < 7; n++) begin
         if (n > 0) cyc();
         #1;
         chk("B_req_valid", o_req_valid, (n <= 3) ? 1 : 0);
         chk("B_occupancy", o_occupancy, (n < 2) ? 0 : ((n - 1 > 4) ? 4 : n - 1));
      end
      chk("B_req_pc_held", o_req_pc, 32'h40);
      chk("B_head_pc", o_issue_pc, 32'h0);
      chk("B_head_bundle", o_issue_bundle, bf(32'h0));
      cyc(); i_issue_ready = 1'b1; #1;                       // c7
      chk("B_c7_issue_pc", o_issue_pc, 32'h0);
      chk("B_c7_req_valid", o_req_valid, 0);
      cyc(); #1;                                            // c8
      chk("B_c8_issue_pc", o_issue_pc, 32'h10);
      chk("B_c8_occupancy", o_occupancy, 3);
      chk("B_c8_req_valid", o_req_valid, 1);
      chk("B_c8_req_pc", o_req_pc, 32'h40);
      cyc(); #1;                                            // c9
      chk("B_c9_issue_pc", o_issue_pc, 32'h20);
      cyc(); #1;                                            // c10
      chk("B_c10_issue_pc", o_issue_pc, 32'h30);
      chk("B_c10_occupancy", o_occupancy, 2);

      // Redirect with three requests in flight.
      do_reset();
      i_rst = 1'b1; i_req_ready = 1'b1; i_issue_ready = 1'b1; mem_go = 1'b0;
      cyc(); cyc(); cyc();                                  // c3
      i_req_ready = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'h200; #1;
      chk("C_redirect_req_valid", o_req_valid, 0);
      cyc(); i_redirect_valid = 1'b0; i_req_ready = 1'b1; mem_go = 1'b1; #1;   // c4
      chk("C_squash", o_squash, 1);
      chk("C_req_pc", o_req_pc, 32'h200);
      chk("C_req_valid", o_req_valid, 1);
      cyc(); #1;                                            // c5
      chk("C_squash_end", o_squash, 0);
      chk("C_credit_full", o_req_valid, 0);
      for (int n = 5; n < 8; n++) begin
         if (n > 5) begin cyc(); #1; end
         chk("C_stale_issue_valid", o_issue_valid, 0);
         chk("C_stale_occupancy", o_occupancy, 0);
      end
      cyc(); #1;                                            // c8
      if (BYP == 1) chk("C_byp_issue_pc", o_issue_pc, 32'h200);
      else          chk("C_c8_issue_valid", o_issue_valid, 0);
      cyc(); #1;                                            // c9
      if (BYP == 0) begin
         chk("C_issue_valid", o_issue_valid, 1);
         chk("C_issue_pc", o_issue_pc, 32'h200);
         chk("C_issue_bundle", o_issue_bundle, bf(32'h200));
      end

      // Unaligned redirect, then a second redirect with a response in the same cycle.
      do_reset();
      i_rst = 1'b1; i_req_ready = 1'b1; i_issue_ready = 1'b1; mem_go = 1'b0;
      cyc(); cyc();                                         // c2
      i_req_ready = 1'b0; i_redirect_valid = 1'b1; i_redirect_pc = 32'h20C;
      cyc(); i_redirect_valid = 1'b0; mem_go = 1'b1; #1;    // c3
      chk("D_aligned_pc", o_req_pc, 32'h200);
      chk("D_squash1", o_squash, 1);
      cyc(); i_redirect_valid = 1'b1; i_redirect_pc = 32'h300; #1;   // c4
      chk("D_rsp_same_cycle", i_rsp_valid, 1);
      chk("D_c4_issue_valid", o_issue_valid, 0);
      chk("D_c4_squash", o_squash, 0);
      cyc(); i_redirect_valid = 1'b0; i_req_ready = 1'b1; #1;        // c5
      chk("D_req_pc", o_req_pc, 32'h300);
      chk("D_squash2", o_squash, 1);
      chk("D_c5_issue_valid", o_issue_valid, 0);
      cyc(); #1;                                            // c6
      chk("D_c6_occupancy", o_occupancy, 0);
      if (BYP == 1) chk("D_byp_issue_pc", o_issue_pc, 32'h300);
      else          chk("D_c6_issue_valid", o_issue_valid, 0);
      cyc(); #1;                                            // c7
      if (BYP == 0) begin
         chk("D_issue_pc", o_issue_pc, 32'h300);
         chk("D_issue_bundle", o_issue_bundle, bf(32'h300));
      end

      // Redirect coincides with an attempted issue handshake.
      do_reset();
      i_rst = 1'b1; i_req_ready = 1'b1; i_issue_ready = 1'b0;
      cyc(); cyc();                                         // c2
      i_issue_ready = 1'b1; i_redirect_valid = 1'b1; i_redirect_pc = 32'h400; #1;
      chk("E_issue_valid", o_issue_valid, 0);
      chk("E_occ_before", o_occupancy, 1);
      cyc(); i_redirect_valid = 1'b0; #1;                   // c3
      chk("E_occupancy", o_occupancy, 0);
      chk("E_squash", o_squash, 1);
      chk("E_req_pc", o_req_pc, 32'h400);
      cyc(); #1;                                            // c4
      if (BYP == 1) chk("E_byp_issue_pc", o_issue_pc, 32'h400);
      cyc(); #1;                                            // c5
      if (BYP == 0) chk("E_issue_pc", o_issue_pc, 32'h400);
      cyc(); i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFF0;  // c6
      cyc(); i_redirect_valid = 1'b0; #1;                   // c7
      chk("F_req_pc_top", o_req_pc, 32'hFFFF_FFF0);
      chk("F_req_valid", o_req_valid, 1);
      cyc(); #1;                                            // c8
      chk("F_req_pc_wrap", o_req_pc, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
